// File: rtl/relu_pkg.sv
// relu_pkg: shared constants and types for the ReLU share dealer.
//   - sh_state_t   : share-register FSM encoding (EMPTY / FULL)
//   - LFSR_TAP*_OFS: Fibonacci LFSR taps, as distances below the MSB of the
//                    2N-bit register (taps 2N, 2N-1, 2N-3, 2N-4)
package relu_pkg;

   typedef enum logic {
      SH_EMPTY = 1'b0,
      SH_FULL  = 1'b1
   } sh_state_t;

   localparam int unsigned LFSR_TAP0_OFS = 0;
   localparam int unsigned LFSR_TAP1_OFS = 1;
   localparam int unsigned LFSR_TAP2_OFS = 3;
   localparam int unsigned LFSR_TAP3_OFS = 4;

endpackage

// File: rtl/relu_share_dealer_mask_fifo.sv
// mask_fifo: DEPTH-entry FIFO holding the r2 masks of issued shares.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_push, i_data  : write one mask
//   i_pop           : discard the head mask
//   o_head          : mask at the head (valid when o_count != 0)
//   o_count         : number of masks held
module mask_fifo #(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [N-1:0]             i_data,
   input  logic                     i_pop,
   output logic [N-1:0]             o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [N-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   // Storage carries no reset; only the pointers and count define contents.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/relu_share_dealer.sv
// relu_share_dealer: masks plaintext x into garbler/evaluator shares using an
// LFSR-drawn mask pair (r1, r2), then unmasks the returned relu(x)+r2.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   seed_valid/seed_ready/seed    : load the 2N-bit LFSR (only when idle)
//   in_valid/in_ready/in_x        : plaintext input
//   sh_valid/sh_ready/sh_g/sh_e   : shares, sh_g={r1,r2}, sh_e=x-r1
//   res_valid/res_ready/res_o     : masked result relu(x)+r2
//   out_valid/out_ready/out_y     : unmasked result res_o-r2
//   pending                       : r2 masks waiting for their result
module relu_share_dealer
   import relu_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     seed_valid,
   output logic                     seed_ready,
   input  logic [2*N-1:0]           seed,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_x,
   output logic                     sh_valid,
   input  logic                     sh_ready,
   output logic [2*N-1:0]           sh_g,
   output logic [N-1:0]             sh_e,
   input  logic                     res_valid,
   output logic                     res_ready,
   input  logic [N-1:0]             res_o,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_y,
   output logic [$clog2(DEPTH):0]   pending
);

   localparam int unsigned PW = $clog2(DEPTH) + 1;

   sh_state_t        r_state;
   sh_state_t        w_state_next;
   logic             r_run;
   logic [2*N-1:0]   r_lfsr;
   logic [2*N-1:0]   w_lfsr_next;
   logic             w_fb;
   logic [2*N-1:0]   r_sh_g;
   logic [N-1:0]     r_sh_e;
   logic             r_out_valid;
   logic [N-1:0]     r_out_y;
   logic [N-1:0]     w_head;
   logic [PW-1:0]    w_count;
   logic [PW-1:0]    w_occ;
   logic             w_seed_xfer;
   logic             w_in_xfer;
   logic             w_sh_xfer;
   logic             w_res_xfer;

   assign w_fb = r_lfsr[2*N-1-LFSR_TAP0_OFS] ^ r_lfsr[2*N-1-LFSR_TAP1_OFS]
               ^ r_lfsr[2*N-1-LFSR_TAP2_OFS] ^ r_lfsr[2*N-1-LFSR_TAP3_OFS];
   assign w_lfsr_next = {r_lfsr[2*N-2:0], w_fb};

   // Masks already queued plus the one sitting in the share register; the
   // FIFO must always have room for every share that can still be pushed.
   assign w_occ = w_count + PW'(r_state == SH_FULL);

   // r_run is cleared asynchronously by rst, so every ready is 0 during reset
   // without using rst as a combinational signal.
   assign seed_ready = r_run && (r_state == SH_EMPTY) && (w_count == '0) && !r_out_valid;
   assign w_seed_xfer = seed_valid && seed_ready;
   assign in_ready = r_run && !w_seed_xfer
                  && ((r_state == SH_EMPTY) || sh_ready)
                  && (w_occ < PW'(DEPTH));
   assign w_in_xfer = in_valid && in_ready;
   assign sh_valid  = (r_state == SH_FULL);
   assign w_sh_xfer = sh_valid && sh_ready;
   assign res_ready = r_run && (w_count != '0) && (!r_out_valid || out_ready);
   assign w_res_xfer = res_valid && res_ready;

   always_comb begin
      w_state_next = r_state;
      if (w_in_xfer)      w_state_next = SH_FULL;
      else if (w_sh_xfer) w_state_next = SH_EMPTY;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= SH_EMPTY;
         r_run       <= 1'b0;
         r_lfsr      <= (2*N)'(1);
         r_sh_g      <= '0;
         r_sh_e      <= '0;
         r_out_valid <= 1'b0;
         r_out_y     <= '0;
      end else begin
         r_state <= w_state_next;
         r_run   <= 1'b1;
         if (w_seed_xfer)    r_lfsr <= (seed == '0) ? (2*N)'(1) : seed;
         else if (w_in_xfer) r_lfsr <= w_lfsr_next;
         if (w_in_xfer) begin
            r_sh_g <= r_lfsr;
            r_sh_e <= in_x - r_lfsr[2*N-1:N];
         end
         if (w_res_xfer) begin
            r_out_valid <= 1'b1;
            r_out_y     <= res_o - w_head;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   mask_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_mask_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_sh_xfer),
      .i_data  (r_sh_g[N-1:0]),
      .i_pop   (w_res_xfer),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign sh_g      = r_sh_g;
   assign sh_e      = r_sh_e;
   assign out_valid = r_out_valid;
   assign out_y     = r_out_y;
   assign pending   = w_count;

endmodule

// File: tb/tb_relu_share_dealer.sv
module tb_relu_share_dealer;

   localparam int unsigned N     = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          seed_valid, seed_ready;
   logic [63:0]   seed;
   logic          in_valid, in_ready;
   logic [31:0]   in_x;
   logic          sh_valid, sh_ready;
   logic [63:0]   sh_g;
   logic [31:0]   sh_e;
   logic          res_valid, res_ready;
   logic [31:0]   res_o;
   logic          out_valid, out_ready;
   logic [31:0]   out_y;
   logic [2:0]    pending;

   int n_total = 0;
   int n_bad   = 0;
   int cnt_in, cnt_sh;

   always #5 clk = ~clk;

   relu_share_dealer #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .seed_valid(seed_valid), .seed_ready(seed_ready), .seed(seed),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .sh_valid(sh_valid), .sh_ready(sh_ready), .sh_g(sh_g), .sh_e(sh_e),
      .res_valid(res_valid), .res_ready(res_ready), .res_o(res_o),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .pending(pending)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_shv"},  sh_valid,   0);
      check_val({tag, "_outv"}, out_valid,  0);
      check_val({tag, "_inr"},  in_ready,   0);
      check_val({tag, "_resr"}, res_ready,  0);
      check_val({tag, "_sdr"},  seed_ready, 0);
      check_val({tag, "_pend"}, pending,    0);
      check_val({tag, "_shg"},  sh_g,       0);
      check_val({tag, "_she"},  sh_e,       0);
      check_val({tag, "_outy"}, out_y,      0);
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b0;
      seed_valid = 0; in_valid = 0; sh_ready = 0; res_valid = 0; out_ready = 0;
      seed = '0; in_x = '0; res_o = '0;
      @(negedge clk);
      check_idle_outputs(tag);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check_val({tag, "_rel_shv"},  sh_valid,  0);
      check_val({tag, "_rel_pend"}, pending,   0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_seed(input logic [63:0] s);
      seed = s; seed_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50 && !seed_ready; i++) @(negedge clk);
      check_val("seed_rdy", seed_ready, 1);
      @(posedge clk); #1 seed_valid = 1'b0;
   endtask

   task automatic send_x(input logic [31:0] x);
      in_x = x; in_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
      check_val("in_rdy", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic take_sh(input string tag, input logic [63:0] exp_g, input logic [31:0] exp_e);
      sh_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50 && !sh_valid; i++) @(negedge clk);
      check_val({tag, "_shv"}, sh_valid, 1);
      check_val({tag, "_shg"}, sh_g, exp_g);
      check_val({tag, "_she"}, sh_e, exp_e);
      @(posedge clk); #1 sh_ready = 1'b0;
   endtask

   task automatic send_res(input logic [31:0] v);
      res_o = v; res_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50 && !res_ready; i++) @(negedge clk);
      check_val("res_rdy", res_ready, 1);
      @(posedge clk); #1 res_valid = 1'b0;
   endtask

   task automatic take_out(input string tag, input logic [31:0] exp_y);
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
      check_val({tag, "_outv"}, out_valid, 1);
      check_val({tag, "_outy"}, out_y, exp_y);
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   initial begin
      apply_reset("por");

      // seed {5,3}, x=0xA: sh_e=5, sh_g={5,3}; res 0xD -> 0xA
      do_seed(64'h00000005_00000003);
      send_x(32'h0000000A);
      take_sh("rt", 64'h00000005_00000003, 32'h00000005);
      check_val("rt_pend1", pending, 1);
      send_res(32'h0000000D);
      take_out("rt", 32'h0000000A);
      check_val("rt_pend0", pending, 0);

      // LFSR stepped once: {5,3}<<1 with zero feedback -> {A,6}
      send_x(32'h00000010);
      take_sh("step", 64'h0000000A_00000006, 32'h00000006);
      send_res(32'h00000020);
      take_out("step", 32'h0000001A);

      // wrap-around
      do_seed(64'hFFFFFFFF_00000002);
      send_x(32'h00000000);
      take_sh("wrap", 64'hFFFFFFFF_00000002, 32'h00000001);
      send_res(32'h00000001);
      take_out("wrap", 32'hFFFFFFFF);

      // feedback bit: only MSB set -> next L = 1, then 2
      do_seed(64'h80000000_00000000);
      send_x(32'h00000000);
      take_sh("fb1", 64'h80000000_00000000, 32'h80000000);
      send_x(32'h00000000);
      take_sh("fb2", 64'h00000000_00000001, 32'h00000000);
      check_val("fb_pend2", pending, 2);
      // seed offered with masks pending must be ignored
      seed = 64'h12345678_9ABCDEF0; seed_valid = 1'b1;
      @(negedge clk);
      check_val("sdign_rdy", seed_ready, 0);
      @(posedge clk); @(posedge clk); #1 seed_valid = 1'b0;
      send_x(32'h00000000);
      take_sh("sdign", 64'h00000000_00000002, 32'h00000000);
      check_val("sdign_pend", pending, 3);
      apply_reset("midrst");

      // zero seed loads 1
      do_seed(64'h0);
      send_x(32'h00000007);
      take_sh("zs", 64'h00000000_00000001, 32'h00000007);
      send_res(32'h00000005);
      take_out("zs", 32'h00000004);

      // back-to-back: 5 inputs offered, only 4 fit
      do_seed(64'h00000005_00000003);
      cnt_in = 0; cnt_sh = 0;
      in_x = 32'h00000001; sh_ready = 1'b1; in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (in_valid && in_ready) cnt_in++;
         if (sh_valid && sh_ready) cnt_sh++;
      end
      check_val("b2b_nin",  cnt_in, 4);
      check_val("b2b_nsh",  cnt_sh, 4);
      check_val("b2b_pend", pending, 4);
      check_val("b2b_inr",  in_ready, 0);
      sh_ready = 1'b0; res_o = 32'h00000100; res_valid = 1'b1; out_ready = 1'b1;
      #1 check_val("b2b_resr", res_ready, 1);
      @(posedge clk); #1 res_valid = 1'b0;
      @(negedge clk);
      check_val("b2b_inr1", in_ready, 1);
      check_val("b2b_pend3", pending, 3);
      check_val("b2b_outy", out_y, 32'h000000FD);
      in_valid = 1'b0;
      apply_reset("b2brst");

      // ordering with output stall; r2 sequence 3, 6, C
      do_seed(64'h00000005_00000003);
      send_x(32'h00000011);
      take_sh("o1", 64'h00000005_00000003, 32'h0000000C);
      send_x(32'h00000022);
      take_sh("o2", 64'h0000000A_00000006, 32'h00000018);
      send_x(32'h00000033);
      take_sh("o3", 64'h00000014_0000000C, 32'h0000001F);
      check_val("ord_pend3", pending, 3);
      send_res(32'h00000100);
      @(negedge clk);
      check_val("ord1_outv", out_valid, 1);
      check_val("ord1_outy", out_y, 32'h000000FD);
      out_ready = 1'b1; res_o = 32'h00000200; res_valid = 1'b1;
      #1 check_val("ord2_resr", res_ready, 1);
      @(posedge clk); #1 out_ready = 1'b0; res_o = 32'h00000300;
      @(negedge clk);
      check_val("ord2_outy", out_y, 32'h000001FA);
      check_val("ord_stall_resr", res_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("ord2_hold_outv", out_valid, 1);
      check_val("ord2_hold_outy", out_y, 32'h000001FA);
      check_val("ord_pend1", pending, 1);
      out_ready = 1'b1;
      #1 check_val("ord3_resr", res_ready, 1);
      @(posedge clk); #1 res_valid = 1'b0;
      @(negedge clk);
      check_val("ord3_outv", out_valid, 1);
      check_val("ord3_outy", out_y, 32'h000002F4);
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      check_val("ord_end_outv", out_valid, 0);
      check_val("ord_end_pend", pending, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
